// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined RV32I control unit.
// Holds opcode values, ALU/immediate/result/PC-source encodings, the
// per-instruction control bundle carried D->E, and the slimmer bundles
// carried E->M and M->W.
package ctrl_pkg;

  // Width of the register index fields inside the bundles. The top's
  // REG_ADDR_W must match this value.
  localparam int RA_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SLTU  = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_B = 3'b001,
    IMM_S = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_REG   = 2'b10
  } pc_src_e;

  // rd is zero whenever RegWrite is clear, and rs1/rs2 are zero when the
  // instruction does not read that source, so hazard/forwarding compares
  // need no per-opcode qualification.
  typedef struct packed {
    logic              RegWrite;
    logic              MemWrite;
    result_src_e       ResultSrc;
    alu_ctrl_e         ALUControl;
    logic              ALUSrcA;
    logic              ALUSrcB;
    logic              Branch;
    logic              Jump;
    logic              Jalr;
    logic [2:0]        funct3;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
  } ctrl_bundle_t;

  typedef struct packed {
    logic            RegWrite;
    logic            MemWrite;
    result_src_e     ResultSrc;
    logic [RA_W-1:0] rd;
  } m_ctrl_t;

  typedef struct packed {
    logic            RegWrite;
    result_src_e     ResultSrc;
    logic [RA_W-1:0] rd;
  } w_ctrl_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // ALU op for R-type and I-arith. instr[30] picks SUB only on R-type,
  // and picks SRA on either form of right shift.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] f3,
                                           input logic       f7,
                                           input logic       is_r);
    alu_ctrl_e a;
    case (f3)
      3'b000:  a = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  // funct3 010/011 are not branch encodings and never redirect.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic zero,
                                        input logic lt,
                                        input logic ltu);
    logic t;
    case (f3)
      3'b000:  t = zero;
      3'b001:  t = !zero;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational D-stage decoder: opcode/funct fields to ctrl_bundle_t.
// Ports: op/funct3/funct7 (instr[30]) and rs1/rs2/rd in; ctrl bundle,
// immediate format and illegal-opcode flag out. Unknown opcodes yield
// an all-zero bundle so they travel down the pipe as a NOP.
import ctrl_pkg::*;

module ctrl_decoder (
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic [RA_W-1:0] rd,
  output ctrl_bundle_t    ctrl,
  output imm_src_e        imm_src,
  output logic            illegal
);

  logic use_rs1, use_rs2;

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    imm_src = IMM_I;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op)
      OP_R: begin
        ctrl.RegWrite   = 1'b1;
        ctrl.ALUControl = alu_decode(funct3, funct7, 1'b1);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I: begin
        ctrl.RegWrite   = 1'b1;
        ctrl.ALUSrcB    = 1'b1;
        ctrl.ALUControl = alu_decode(funct3, funct7, 1'b0);
        use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.RegWrite  = 1'b1;
        ctrl.ResultSrc = RES_MEM;
        ctrl.ALUSrcB   = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl.MemWrite = 1'b1;
        ctrl.ALUSrcB  = 1'b1;
        imm_src = IMM_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.Branch     = 1'b1;
        ctrl.ALUControl = ALU_SUB;
        imm_src = IMM_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        // ALU forms PC+imm; the link value comes from the PC+4 path.
        ctrl.RegWrite  = 1'b1;
        ctrl.ResultSrc = RES_PC4;
        ctrl.Jump      = 1'b1;
        ctrl.ALUSrcA   = 1'b1;
        ctrl.ALUSrcB   = 1'b1;
        imm_src = IMM_J;
      end
      OP_JALR: begin
        ctrl.RegWrite  = 1'b1;
        ctrl.ResultSrc = RES_PC4;
        ctrl.Jalr      = 1'b1;
        ctrl.ALUSrcB   = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LUI: begin
        ctrl.RegWrite   = 1'b1;
        ctrl.ALUSrcB    = 1'b1;
        ctrl.ALUControl = ALU_PASSB;
        imm_src = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.RegWrite = 1'b1;
        ctrl.ALUSrcA  = 1'b1;
        ctrl.ALUSrcB  = 1'b1;
        imm_src = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    if (!illegal) ctrl.funct3 = funct3;
    // Zero unused register fields so x0 comparisons mask them downstream.
    if (ctrl.RegWrite) ctrl.rd  = rd;
    if (use_rs1)       ctrl.rs1 = rs1;
    if (use_rs2)       ctrl.rs2 = rs2;
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control and hazard unit for a 5-stage (F/D/E/M/W) RV32I core.
// Decodes the D-stage instruction, carries control through D->E, E->M,
// M->W registers, resolves branches/jumps in E and produces stall,
// flush and forwarding selects.
// Ports: clk_i, rst_ni (async, active low); D-stage op/funct/reg fields;
// E-stage ALU flags Zero/Lt/Ltu. Outputs: ImmSrc/Illegal (D), ALU
// controls and PCSrc (E), MemWrite (M), RegWrite/ResultSrc/rd (W),
// StallF/StallD/FlushD/FlushE and ForwardA/ForwardB.
// Build option CTRL_FORWARDING_EN: when defined, E-stage operands are
// forwarded from M/W and only load-use stalls; when undefined, forward
// selects are 00 and any RAW dependency on E or M stalls instead.
// All outputs are forced to zero while rst_ni is low.
import ctrl_pkg::*;

module pipelined_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_i,
  input  logic [REG_ADDR_W-1:0] rs1_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_d_i,
  input  logic [REG_ADDR_W-1:0] rd_d_i,
  input  logic                  Zero_e_i,
  input  logic                  Lt_e_i,
  input  logic                  Ltu_e_i,
  output logic [2:0]            ImmSrc_d_o,
  output logic                  Illegal_d_o,
  output logic [ALU_CTRL_W-1:0] ALUControl_e_o,
  output logic                  ALUSrcA_e_o,
  output logic                  ALUSrcB_e_o,
  output logic [1:0]            PCSrc_e_o,
  output logic                  MemWrite_m_o,
  output logic                  RegWrite_w_o,
  output logic [1:0]            ResultSrc_w_o,
  output logic [REG_ADDR_W-1:0] rd_w_o,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic [1:0]            ForwardA_e_o,
  output logic [1:0]            ForwardB_e_o
);

  ctrl_bundle_t dec, e_q;
  m_ctrl_t      m_q;
  w_ctrl_t      w_q;
  imm_src_e     imm_src;
  logic         illegal;
  pc_src_e      pc_src;
  logic         redirect, hazard, stall, flush_e;
  logic [1:0]   fwd_a, fwd_b;

  ctrl_decoder u_dec (
    .op      (op_i),
    .funct3  (funct3_i),
    .funct7  (funct7_i),
    .rs1     (RA_W'(rs1_d_i)),
    .rs2     (RA_W'(rs2_d_i)),
    .rd      (RA_W'(rd_d_i)),
    .ctrl    (dec),
    .imm_src (imm_src),
    .illegal (illegal)
  );

  // ---------------- E-stage redirect ----------------
  always_comb begin
    pc_src = PC_PLUS4;
    if (e_q.Jalr)
      pc_src = PC_REG;
    else if (e_q.Jump ||
             (e_q.Branch && branch_taken(e_q.funct3, Zero_e_i, Lt_e_i, Ltu_e_i)))
      pc_src = PC_IMM;
  end

  assign redirect = (pc_src != PC_PLUS4);

  // ---------------- Hazards / forwarding ----------------
  // Unused sources are zero in the bundle, so a nonzero producer rd can
  // only match a register the D instruction really reads.
  function automatic logic src_hit(input ctrl_bundle_t d, input logic [RA_W-1:0] prd);
    return (prd != '0) && ((d.rs1 == prd) || (d.rs2 == prd));
  endfunction

`ifdef CTRL_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (m_q.RegWrite && m_q.rd != '0 && m_q.rd == rs) return 2'b10;
    if (w_q.RegWrite && w_q.rd != '0 && w_q.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  assign hazard = (e_q.ResultSrc == RES_MEM) && src_hit(dec, e_q.rd);
  assign fwd_a  = fwd_sel(e_q.rs1);
  assign fwd_b  = fwd_sel(e_q.rs2);
`else
  // W never needs a stall: the register file writes on the falling edge.
  assign hazard = (e_q.RegWrite && src_hit(dec, e_q.rd)) ||
                  (m_q.RegWrite && src_hit(dec, m_q.rd));
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;

  logic unused_src;
  assign unused_src = ^{e_q.rs1, e_q.rs2};
`endif

  // A taken transfer squashes the dependent D instruction anyway, so the
  // flush wins and the front end must not be held.
  assign stall   = hazard && !redirect;
  assign flush_e = redirect || hazard;

  // ---------------- Stage registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e_q <= CTRL_BUBBLE;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= flush_e ? CTRL_BUBBLE : dec;
      m_q <= '{RegWrite: e_q.RegWrite, MemWrite: e_q.MemWrite,
               ResultSrc: e_q.ResultSrc, rd: e_q.rd};
      w_q <= '{RegWrite: m_q.RegWrite, ResultSrc: m_q.ResultSrc, rd: m_q.rd};
    end
  end

  // ---------------- Outputs (zero while in reset) ----------------
  assign ImmSrc_d_o     = rst_ni ? imm_src : 3'b000;
  assign Illegal_d_o    = rst_ni && illegal;
  assign ALUControl_e_o = rst_ni ? ALU_CTRL_W'(e_q.ALUControl) : '0;
  assign ALUSrcA_e_o    = rst_ni && e_q.ALUSrcA;
  assign ALUSrcB_e_o    = rst_ni && e_q.ALUSrcB;
  assign PCSrc_e_o      = rst_ni ? pc_src : 2'b00;
  assign MemWrite_m_o   = rst_ni && m_q.MemWrite;
  assign RegWrite_w_o   = rst_ni && w_q.RegWrite;
  assign ResultSrc_w_o  = rst_ni ? w_q.ResultSrc : 2'b00;
  assign rd_w_o         = rst_ni ? REG_ADDR_W'(w_q.rd) : '0;
  assign StallF_o       = rst_ni && stall;
  assign StallD_o       = rst_ni && stall;
  assign FlushD_o       = rst_ni && redirect;
  assign FlushE_o       = rst_ni && flush_e;
  assign ForwardA_e_o   = rst_ni ? fwd_a : 2'b00;
  assign ForwardB_e_o   = rst_ni ? fwd_b : 2'b00;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios plus
// randomized instruction streams, compared every cycle against an
// instruction-level reference model of the D/E/M/W pipeline.
module tb_pipelined_control_unit;

  localparam int RW = 5;
  localparam int AW = 4;

  localparam bit [6:0] R_ = 7'h33, I_ = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63,
                       JL = 7'h6F, JR = 7'h67, LU = 7'h37, AP = 7'h17;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic f7;
  logic [RW-1:0] rs1, rs2, rd;
  logic zf, ltf, ltuf;
  logic [2:0] imm_o;
  logic ill_o, srca_o, srcb_o, memw_o, regw_o, stf_o, std_o, fld_o, fle_o;
  logic [AW-1:0] alu_o;
  logic [1:0] pcs_o, res_o, fa_o, fb_o;
  logic [RW-1:0] rdw_o;

  pipelined_control_unit #(.REG_ADDR_W(RW), .ALU_CTRL_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct3_i(f3), .funct7_i(f7),
    .rs1_d_i(rs1), .rs2_d_i(rs2), .rd_d_i(rd),
    .Zero_e_i(zf), .Lt_e_i(ltf), .Ltu_e_i(ltuf),
    .ImmSrc_d_o(imm_o), .Illegal_d_o(ill_o), .ALUControl_e_o(alu_o),
    .ALUSrcA_e_o(srca_o), .ALUSrcB_e_o(srcb_o), .PCSrc_e_o(pcs_o),
    .MemWrite_m_o(memw_o), .RegWrite_w_o(regw_o), .ResultSrc_w_o(res_o),
    .rd_w_o(rdw_o), .StallF_o(stf_o), .StallD_o(std_o), .FlushD_o(fld_o),
    .FlushE_o(fle_o), .ForwardA_e_o(fa_o), .ForwardB_e_o(fb_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [6:0] op; bit [2:0] f3; bit f7; bit [4:0] rd, rs1, rs2;
  } ins_t;
  typedef enum int {K_R, K_I, K_LD, K_ST, K_B, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_e;

  ins_t ex, mm, wb, bub;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- Reference model (instruction level) ----------------
  function automatic ins_t mk(bit [6:0] o, bit [2:0] fn3, bit fn7, bit [4:0] d, bit [4:0] s1, bit [4:0] s2);
    ins_t i;
    i.op = o; i.f3 = fn3; i.f7 = fn7; i.rd = d; i.rs1 = s1; i.rs2 = s2;
    return i;
  endfunction

  function automatic kind_e kind(bit [6:0] o);
    case (o)
      R_: return K_R;   I_: return K_I;   LD: return K_LD;
      ST: return K_ST;  BR: return K_B;   JL: return K_JAL;
      JR: return K_JALR; LU: return K_LUI; AP: return K_AUIPC;
      default: return K_BAD;
    endcase
  endfunction

  function automatic bit writes(ins_t i);
    kind_e k = kind(i.op);
    return k inside {K_R, K_I, K_LD, K_JAL, K_JALR, K_LUI, K_AUIPC};
  endfunction

  function automatic int dest(ins_t i);   return writes(i) ? int'(i.rd) : 0; endfunction
  // Register actually read by the instruction; x0 stands for "none".
  function automatic int src1(ins_t i);
    return (kind(i.op) inside {K_R, K_I, K_LD, K_ST, K_B, K_JALR}) ? int'(i.rs1) : 0;
  endfunction
  function automatic int src2(ins_t i);
    return (kind(i.op) inside {K_R, K_ST, K_B}) ? int'(i.rs2) : 0;
  endfunction

  function automatic int alu(ins_t i);
    int tbl[8] = '{0, 6, 5, 7, 4, 8, 3, 2};
    int v;
    case (kind(i.op))
      K_R, K_I: begin
        v = tbl[i.f3];
        if (i.f3 == 3'd5 && i.f7) v = 9;
        if (i.f3 == 3'd0 && i.f7 && kind(i.op) == K_R) v = 1;
        return v;
      end
      K_B:   return 1;
      K_LUI: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int imm(ins_t i);
    case (kind(i.op))
      K_B: return 1; K_ST: return 2; K_LUI, K_AUIPC: return 3; K_JAL: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int srca(ins_t i); return (kind(i.op) inside {K_AUIPC, K_JAL}) ? 1 : 0; endfunction
  function automatic int srcb(ins_t i);
    return (kind(i.op) inside {K_I, K_LD, K_ST, K_LUI, K_AUIPC, K_JAL, K_JALR}) ? 1 : 0;
  endfunction
  function automatic int ressrc(ins_t i);
    case (kind(i.op)) K_LD: return 1; K_JAL, K_JALR: return 2; default: return 0; endcase
  endfunction

  function automatic int pcsrc(ins_t i, bit z, bit lt, bit ltu);
    bit t;
    case (i.f3)
      3'd0: t = z;  3'd1: t = !z; 3'd4: t = lt; 3'd5: t = !lt;
      3'd6: t = ltu; 3'd7: t = !ltu; default: t = 0;
    endcase
    case (kind(i.op))
      K_JALR: return 2;
      K_JAL:  return 1;
      K_B:    return t ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit hit(ins_t d, int prd);
    return prd != 0 && (src1(d) == prd || src2(d) == prd);
  endfunction

  function automatic int fwd(int rs);
`ifdef CTRL_FORWARDING_EN
    if (rs != 0 && rs == dest(mm)) return 2;
    if (rs != 0 && rs == dest(wb)) return 1;
`endif
    return 0 * rs;
  endfunction

  // One clock: drive D instruction and flags, compare all outputs, advance model.
  task automatic step(input ins_t d, input bit z, input bit lt, input bit ltu, output bit stalled);
    int pcs;
    bit haz;
    @(negedge clk);
    op = d.op; f3 = d.f3; f7 = d.f7; rd = d.rd; rs1 = d.rs1; rs2 = d.rs2;
    zf = z; ltf = lt; ltuf = ltu;
    #1;
    pcs = pcsrc(ex, z, lt, ltu);
`ifdef CTRL_FORWARDING_EN
    haz = kind(ex.op) == K_LD && hit(d, dest(ex));
`else
    haz = hit(d, dest(ex)) || hit(d, dest(mm));
`endif
    check("imm_src",   32'(imm_o),  imm(d));
    check("illegal",   32'(ill_o),  kind(d.op) == K_BAD ? 1 : 0);
    check("alu_ctrl",  32'(alu_o),  alu(ex));
    check("alu_src_a", 32'(srca_o), srca(ex));
    check("alu_src_b", 32'(srcb_o), srcb(ex));
    check("pc_src",    32'(pcs_o),  pcs);
    check("mem_write", 32'(memw_o), kind(mm.op) == K_ST ? 1 : 0);
    check("reg_write", 32'(regw_o), writes(wb) ? 1 : 0);
    check("res_src",   32'(res_o),  ressrc(wb));
    check("rd_w",      32'(rdw_o),  dest(wb));
    check("stall_f",   32'(stf_o),  (haz && pcs == 0) ? 1 : 0);
    check("stall_d",   32'(std_o),  (haz && pcs == 0) ? 1 : 0);
    check("flush_d",   32'(fld_o),  pcs != 0 ? 1 : 0);
    check("flush_e",   32'(fle_o),  (pcs != 0 || haz) ? 1 : 0);
    check("fwd_a",     32'(fa_o),   fwd(src1(ex)));
    check("fwd_b",     32'(fb_o),   fwd(src2(ex)));
    wb = mm;
    mm = ex;
    ex = (pcs != 0 || haz) ? bub : d;
    stalled = haz && pcs == 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_imm"}, 32'(imm_o), 0);  check({tag, "_ill"}, 32'(ill_o), 0);
    check({tag, "_alu"}, 32'(alu_o), 0);  check({tag, "_sa"}, 32'(srca_o), 0);
    check({tag, "_sb"}, 32'(srcb_o), 0);  check({tag, "_pcs"}, 32'(pcs_o), 0);
    check({tag, "_mw"}, 32'(memw_o), 0);  check({tag, "_rw"}, 32'(regw_o), 0);
    check({tag, "_res"}, 32'(res_o), 0);  check({tag, "_rd"}, 32'(rdw_o), 0);
    check({tag, "_stf"}, 32'(stf_o), 0);  check({tag, "_std"}, 32'(std_o), 0);
    check({tag, "_fld"}, 32'(fld_o), 0);  check({tag, "_fle"}, 32'(fle_o), 0);
    check({tag, "_fa"}, 32'(fa_o), 0);    check({tag, "_fb"}, 32'(fb_o), 0);
  endtask

  function automatic ins_t rnd();
    bit [6:0] ops[10] = '{R_, I_, LD, ST, BR, JL, JR, LU, AP, 7'h7F};
    int k = $urandom_range(0, 9);
    bit [6:0] o = ops[k];
    if (k == 9 && $urandom_range(0, 1) == 1) o = 7'($urandom_range(0, 127));
    return mk(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
  endfunction

  ins_t nop, addi, d;
  bit st;

  initial begin
    bub = mk(0, 0, 0, 0, 0, 0);
    nop = mk(I_, 0, 0, 0, 0, 0);
    addi = mk(R_, 0, 0, 1, 2, 3);
    ex = bub; mm = bub; wb = bub;
    rst_n = 1'b0;
    op = 7'h7F; f3 = 0; f7 = 0; rd = 0; rs1 = 0; rs2 = 0; zf = 0; ltf = 0; ltuf = 0;
    #1;
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream reset with a pipe full of ADDs.
    repeat (4) step(addi, 0, 0, 0, st);
    rst_n = 1'b0;
    op = 7'h7F;
    #1;
    check_zero("mid_rst");
    op = LU;
    #1;
    check("mid_rst_imm", 32'(imm_o), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    ex = bub; mm = bub; wb = bub;
    step(mk(R_, 0, 0, 7, 1, 2), 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    check("rst_add_w_regwrite", 32'(regw_o), 1);
    check("rst_add_w_rd", 32'(rdw_o), 7);

    // lw x5,0(x1); add x6,x5,x2
    step(mk(LD, 3'd2, 0, 5, 1, 0), 0, 0, 0, st);
    step(mk(R_, 0, 0, 6, 5, 2), 0, 0, 0, st);
    check("lu_stall_f", 32'(stf_o), 1);
    check("lu_flush_e", 32'(fle_o), 1);
`ifdef CTRL_FORWARDING_EN
    step(mk(R_, 0, 0, 6, 5, 2), 0, 0, 0, st);
    check("lu_released", 32'(stf_o), 0);
    step(nop, 0, 0, 0, st);
    check("lu_fwd_a", 32'(fa_o), 1);
`else
    step(mk(R_, 0, 0, 6, 5, 2), 0, 0, 0, st);
    check("lu_stall2", 32'(stf_o), 1);
    step(mk(R_, 0, 0, 6, 5, 2), 0, 0, 0, st);
    check("lu_released", 32'(stf_o), 0);
`endif
    repeat (3) step(nop, 0, 0, 0, st);

    // add x3,x1,x2; sub x4,x3,x3 (back-to-back and with one gap)
    step(mk(R_, 0, 0, 3, 1, 2), 0, 0, 0, st);
`ifdef CTRL_FORWARDING_EN
    step(mk(R_, 0, 1, 4, 3, 3), 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    check("raw_fwd_a_m", 32'(fa_o), 2);
    check("raw_fwd_b_m", 32'(fb_o), 2);
    step(mk(R_, 0, 0, 3, 1, 2), 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    step(mk(R_, 0, 1, 4, 3, 3), 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    check("raw_fwd_a_w", 32'(fa_o), 1);
    check("raw_fwd_b_w", 32'(fb_o), 1);
`else
    step(mk(R_, 0, 1, 4, 3, 3), 0, 0, 0, st);
    check("raw_stall1", 32'(stf_o), 1);
    step(mk(R_, 0, 1, 4, 3, 3), 0, 0, 0, st);
    check("raw_stall2", 32'(stf_o), 1);
    step(mk(R_, 0, 1, 4, 3, 3), 0, 0, 0, st);
    check("raw_go", 32'(stf_o), 0);
`endif
    repeat (3) step(nop, 0, 0, 0, st);

    // bltu taken, bge with Lt=1 not taken
    step(mk(BR, 3'd6, 0, 0, 1, 2), 0, 0, 0, st);
    step(nop, 0, 0, 1, st);
    check("bltu_pcsrc", 32'(pcs_o), 1);
    check("bltu_flush_d", 32'(fld_o), 1);
    check("bltu_flush_e", 32'(fle_o), 1);
    step(mk(BR, 3'd5, 0, 0, 1, 2), 0, 0, 0, st);
    step(nop, 0, 1, 0, st);
    check("bge_not_taken", 32'(pcs_o), 0);

    // jalr in E with a dependent instruction in D: flush wins
    repeat (3) step(nop, 0, 0, 0, st);
    step(mk(LD, 3'd2, 0, 7, 1, 0), 0, 0, 0, st);
    step(mk(JR, 0, 0, 1, 5, 0), 0, 0, 0, st);
    step(mk(R_, 0, 0, 8, 7, 0), 0, 0, 0, st);
    check("jalr_pcsrc", 32'(pcs_o), 2);
    check("jalr_flush_d", 32'(fld_o), 1);
    check("jalr_flush_e", 32'(fle_o), 1);
    check("jalr_no_stall", 32'(stf_o), 0);

    // illegal opcode and x0 destination
    repeat (3) step(nop, 0, 0, 0, st);
    step(mk(7'h7F, 0, 0, 5, 1, 2), 0, 0, 0, st);
    check("illegal_d", 32'(ill_o), 1);
    step(nop, 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    check("illegal_m_memw", 32'(memw_o), 0);
    step(nop, 0, 0, 0, st);
    check("illegal_w_regw", 32'(regw_o), 0);
    step(mk(R_, 0, 0, 0, 1, 2), 0, 0, 0, st);
    step(mk(R_, 0, 0, 3, 0, 0), 0, 0, 0, st);
    step(nop, 0, 0, 0, st);
    check("x0_no_fwd_a", 32'(fa_o), 0);
    check("x0_no_fwd_b", 32'(fb_o), 0);

    // Random stream; a stalled D instruction is re-presented, as the held
    // IF/ID register would do.
    d = rnd();
    for (int n = 0; n < 800; n++) begin
      step(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st);
      if (!st) d = rnd();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
